dbus_responder: RTL and testbench

DBUS_RESPONDER -- requirements
Module: dbus_responder

---
 rtl/common_pkg.sv | 32 +++
 rtl/resp_mem.sv | 44 ++++
 rtl/dbus_responder.sv | 148 ++++++++++++++
 tb/tb_dbus_responder.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/common_pkg.sv
// ---------------------------------------------------------------------------
// common -- shared types for the core data bus.
//
// dbus_req_t  : request from the core (valid, byte address, access size,
//               byte-lane write strobe, write data). strobe == 0 means read.
// dbus_resp_t : response to the core (addr_ok handshake, data_ok completion,
//               read data).
// dresp_state_t : state encoding of the data-bus responder FSM.
// ---------------------------------------------------------------------------
package common;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dresp_state_t;

endpackage

// File: rtl/resp_mem.sv
// ---------------------------------------------------------------------------
// resp_mem -- DEPTH x 64-bit word store for the data-bus responder.
//
// Ports:
//   clk    : write clock
//   we     : write enable, applied at the rising edge
//   waddr  : word index for the write
//   wstrb  : byte-lane enables, bit i covers wdata[8i+7:8i]
//   wdata  : write data
//   raddr  : word index for the asynchronous read
//   rdata  : word at raddr; reflects the pre-write contents in the cycle of
//            a write to the same word
//
// The array has no reset so that its contents survive a responder reset.
// ---------------------------------------------------------------------------
module resp_mem #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned IDX_W = 8
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [7:0]       wstrb,
    input  logic [63:0]      wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [63:0]      rdata
);

    logic [63:0] mem_q [DEPTH];

    assign rdata = mem_q[raddr];

    // Byte-strobed write: only enabled lanes of the addressed word change.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 8; i++) begin
                if (wstrb[i]) begin
                    mem_q[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/dbus_responder.sv
// ---------------------------------------------------------------------------
// dbus_responder -- fixed-latency memory responder on the core data bus.
//
// Parameters:
//   DEPTH   : number of 64-bit words (power of two)
//   LATENCY : cycles from acceptance (addr_ok) to completion (data_ok), 1..15
//   BASE    : byte address of word 0
//
// Ports:
//   clk     : clock, rising edge
//   reset   : asynchronous active-high reset
//   dreq    : request from the core
//   dresp   : addr_ok / data_ok / read data back to the core
//   oob     : one-cycle pulse with data_ok when the request missed the window
//   txn_cnt : number of completed transactions, wraps at 2^32
//
// One request is in flight at a time. Address, strobe and data are captured
// at acceptance, so the core may change or withdraw dreq afterwards. Reads
// return the whole aligned word; writes return the word as it was before
// the write lands at the end of the completion cycle.
// ---------------------------------------------------------------------------
module dbus_responder
    import common::*;
#(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2,
    parameter logic [63:0] BASE    = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  dbus_req_t   dreq,
    output dbus_resp_t  dresp,
    output logic        oob,
    output logic [31:0] txn_cnt
);

    localparam int unsigned IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    dresp_state_t state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [63:0]  addr_q, addr_d;
    logic [7:0]   strobe_q, strobe_d;
    logic [63:0]  data_q, data_d;
    logic [31:0]  txn_cnt_q, txn_cnt_d;

    logic [63:0]      offset;
    logic [63:0]      word_off;
    logic             in_range;
    logic             in_resp;
    logic             mem_we;
    logic [IDX_W-1:0] mem_idx;
    logic [63:0]      mem_rdata;
    logic             unused_size;

    // Access size plays no part: the full aligned word is always returned.
    assign unused_size = ^dreq.size;

    // Range check on the captured address. Comparing the word offset against
    // DEPTH avoids forming BASE+DEPTH*8, which could overflow for high BASE.
    assign offset   = addr_q - BASE;
    assign word_off = offset >> 3;
    assign in_range = (addr_q >= BASE) && (word_off < 64'(DEPTH));
    assign mem_idx  = word_off[IDX_W-1:0];

    assign in_resp = (state_q == RESP);
    assign mem_we  = in_resp && in_range && (strobe_q != 8'h00);

    // Next-state logic: capture on acceptance, count down the latency,
    // complete for exactly one cycle, then return to IDLE.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        strobe_d  = strobe_q;
        data_d    = data_q;
        txn_cnt_d = txn_cnt_q;
        case (state_q)
            IDLE: begin
                if (dreq.valid) begin
                    addr_d   = dreq.addr;
                    strobe_d = dreq.strobe;
                    data_d   = dreq.data;
                    cnt_d    = CNT_INIT;
                    state_d  = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d   = IDLE;
                txn_cnt_d = txn_cnt_q + 32'd1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            addr_q    <= '0;
            strobe_q  <= '0;
            data_q    <= '0;
            txn_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            strobe_q  <= strobe_d;
            data_q    <= data_d;
            txn_cnt_q <= txn_cnt_d;
        end
    end

    // Response outputs. addr_ok is held low while reset is asserted because
    // a request accepted then would be discarded anyway.
    always_comb begin
        dresp         = '0;
        dresp.addr_ok = !reset && (state_q == IDLE) && dreq.valid;
        dresp.data_ok = in_resp;
        dresp.data    = (in_resp && in_range) ? mem_rdata : 64'h0;
    end

    assign oob     = in_resp && !in_range;
    assign txn_cnt = txn_cnt_q;

    resp_mem #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_idx),
        .wstrb (strobe_q),
        .wdata (data_q),
        .raddr (mem_idx),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_dbus_responder.sv
// ---------------------------------------------------------------------------
// tb_dbus_responder -- directed scoreboard bench for dbus_responder.
//
// dut  : DEPTH=256, LATENCY=2, BASE=8000_0000 (main functional tests)
// dut1 : DEPTH=16,  LATENCY=1 (back-to-back acceptance)
//
// Stimulus pushes the expected completion into a queue at acceptance time;
// a monitor per DUT pops and compares whenever data_ok is seen.
// ---------------------------------------------------------------------------
module tb_dbus_responder;
    import common::*;

    typedef struct packed {
        logic [63:0] data;
        logic        oob;
        logic        care;
    } exp_t;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    dbus_req_t   dreq;
    dbus_resp_t  dresp;
    logic        oob;
    logic [31:0] txn_cnt;
    dbus_req_t   dreq1;
    dbus_resp_t  dresp1;
    logic        oob1;
    logic [31:0] txn_cnt1;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_txn = 32'd0;
    exp_t        sb_q[$];
    exp_t        sb1_q[$];

    always #5 clk = ~clk;

    dbus_responder #(
        .DEPTH   (256),
        .LATENCY (2),
        .BASE    (64'h8000_0000)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .dreq    (dreq),
        .dresp   (dresp),
        .oob     (oob),
        .txn_cnt (txn_cnt)
    );

    dbus_responder #(
        .DEPTH   (16),
        .LATENCY (1),
        .BASE    (64'h8000_0000)
    ) dut1 (
        .clk     (clk),
        .reset   (reset),
        .dreq    (dreq1),
        .dresp   (dresp1),
        .oob     (oob1),
        .txn_cnt (txn_cnt1)
    );

    function automatic exp_t mk_exp(input logic [63:0] d, input logic o, input logic c);
        exp_t e;
        e.data = d;
        e.oob  = o;
        e.care = c;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Monitor for dut: completions are compared against the scoreboard,
    // and outside completions data/oob must be quiet.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (dresp.data_ok) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected data_ok: got 1, expected 0");
                end else begin
                    e = sb_q.pop_front();
                    if (e.care) checkOutput("resp data", dresp.data, e.data);
                    checkOutput("resp oob", 64'(oob), 64'(e.oob));
                end
            end else begin
                checkOutput("idle data", dresp.data, 64'h0);
                checkOutput("idle oob", 64'(oob), 64'h0);
            end
        end
    end

    // Monitor for dut1.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && dresp1.data_ok) begin
            if (sb1_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL dut1 unexpected data_ok: got 1, expected 0");
            end else begin
                e = sb1_q.pop_front();
                if (e.care) checkOutput("dut1 resp data", dresp1.data, e.data);
                checkOutput("dut1 resp oob", 64'(oob1), 64'(e.oob));
            end
        end
    end

    // One LATENCY=2 transaction on dut. With withdraw=1 the request is
    // dropped and its fields scrambled in the cycle after acceptance.
    task automatic applyStimulus(input logic [63:0] addr, input logic [7:0] strobe,
                                 input logic [63:0] wdata, input logic [63:0] exp_data,
                                 input logic exp_care, input logic exp_oob,
                                 input logic withdraw);
        @(posedge clk); #1;
        dreq.valid  = 1'b1;
        dreq.addr   = addr;
        dreq.size   = 3'd3;
        dreq.strobe = strobe;
        dreq.data   = wdata;
        @(negedge clk);
        checkOutput("addr_ok at accept", 64'(dresp.addr_ok), 64'h1);
        checkOutput("data_ok at accept", 64'(dresp.data_ok), 64'h0);
        sb_q.push_back(mk_exp(exp_data, exp_oob, exp_care));
        @(posedge clk); #1;
        if (withdraw) begin
            dreq.valid  = 1'b0;
            dreq.addr   = 64'h8000_0010;
            dreq.strobe = 8'hFF;
            dreq.data   = '1;
        end
        @(negedge clk);
        checkOutput("addr_ok in WAIT", 64'(dresp.addr_ok), 64'h0);
        checkOutput("data_ok in WAIT", 64'(dresp.data_ok), 64'h0);
        @(posedge clk); #1;
        dreq.valid = 1'b0;
        @(negedge clk);
        checkOutput("data_ok at t+2", 64'(dresp.data_ok), 64'h1);
        exp_txn++;
        @(negedge clk);
        checkOutput("data_ok single cycle", 64'(dresp.data_ok), 64'h0);
        checkOutput("addr_ok after RESP", 64'(dresp.addr_ok), 64'h0);
        checkOutput("txn_cnt", 64'(txn_cnt), 64'(exp_txn));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        dreq       = '0;
        dreq1      = '0;
        // A valid request during reset must not be acknowledged.
        dreq.valid = 1'b1;
        dreq.addr  = 64'h8000_0000;
        repeat (2) @(negedge clk);
        checkOutput("reset addr_ok", 64'(dresp.addr_ok), 64'h0);
        checkOutput("reset data_ok", 64'(dresp.data_ok), 64'h0);
        checkOutput("reset data", dresp.data, 64'h0);
        checkOutput("reset oob", 64'(oob), 64'h0);
        checkOutput("reset txn_cnt", 64'(txn_cnt), 64'h0);
        checkOutput("reset dut1 txn_cnt", 64'(txn_cnt1), 64'h0);
        @(posedge clk); #1;
        dreq  = '0;
        reset = 1'b0;

        // Preload words 0 and 1, then reset: contents must survive it.
        applyStimulus(64'h8000_0000, 8'hFF, 64'h1122_3344_5566_7788, 64'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(64'h8000_0008, 8'hFF, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        reset   = 1'b1;
        exp_txn = 32'd0;
        @(negedge clk);
        checkOutput("txn_cnt cleared by reset", 64'(txn_cnt), 64'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Aligned read of word 0.
        applyStimulus(64'h8000_0000, 8'h00, 64'h0, 64'h1122_3344_5566_7788, 1'b1, 1'b0, 1'b0);
        // Byte write to word 1 (lanes 1,2), returns old word, then read back.
        applyStimulus(64'h8000_0008, 8'b0000_0110, 64'hAABB_CCDD_EEFF_0011,
                      64'h0, 1'b1, 1'b0, 1'b0);
        applyStimulus(64'h8000_0008, 8'h00, 64'h0, 64'h0000_0000_00FF_0000, 1'b1, 1'b0, 1'b0);
        // Outer lanes of word 0, then a misaligned read of the same word.
        applyStimulus(64'h8000_0000, 8'b1000_0001, 64'hAABB_CCDD_EEFF_0011,
                      64'h1122_3344_5566_7788, 1'b1, 1'b0, 1'b0);
        applyStimulus(64'h8000_0004, 8'h00, 64'h0, 64'hAA22_3344_5566_7711, 1'b1, 1'b0, 1'b0);
        // Last in-range word, read through its highest byte address.
        applyStimulus(64'h8000_07F8, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(64'h8000_07FF, 8'h00, 64'h0, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b0, 1'b0);
        // Out of range above and below the window.
        applyStimulus(64'h8000_0800, 8'h00, 64'h0, 64'h0, 1'b1, 1'b1, 1'b0);
        applyStimulus(64'h8000_0800, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, 64'h0, 1'b1, 1'b1, 1'b0);
        applyStimulus(64'h7FFF_FFF8, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, 64'h0, 1'b1, 1'b1, 1'b0);
        applyStimulus(64'h8000_0000, 8'h00, 64'h0, 64'hAA22_3344_5566_7711, 1'b1, 1'b0, 1'b0);
        applyStimulus(64'h8000_07F8, 8'h00, 64'h0, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b0, 1'b0);

        // Withdrawal after acceptance still completes; scrambled fields ignored.
        applyStimulus(64'h8000_0008, 8'h00, 64'h0, 64'h0000_0000_00FF_0000, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("no re-accept after withdraw", 64'(dresp.addr_ok), 64'h0);
        applyStimulus(64'h8000_0008, 8'h00, 64'h0, 64'h0000_0000_00FF_0000, 1'b1, 1'b0, 1'b0);

        // Reset one cycle after accepting a write aborts it.
        @(posedge clk); #1;
        dreq.valid  = 1'b1;
        dreq.addr   = 64'h8000_0000;
        dreq.strobe = 8'hFF;
        dreq.data   = 64'hDEAD_BEEF_0BAD_F00D;
        @(negedge clk);
        checkOutput("abort addr_ok at accept", 64'(dresp.addr_ok), 64'h1);
        @(posedge clk); #1;
        dreq.valid = 1'b0;
        reset      = 1'b1;
        exp_txn    = 32'd0;
        @(negedge clk);
        checkOutput("abort data_ok in reset", 64'(dresp.data_ok), 64'h0);
        checkOutput("abort txn_cnt", 64'(txn_cnt), 64'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("abort no data_ok", 64'(dresp.data_ok), 64'h0);
        end
        applyStimulus(64'h8000_0000, 8'h00, 64'h0, 64'hAA22_3344_5566_7711, 1'b1, 1'b0, 1'b0);

        // Counter wrap.
        force dut.txn_cnt_q = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        release dut.txn_cnt_q;
        @(negedge clk);
        checkOutput("txn_cnt preset", 64'(txn_cnt), 64'hFFFF_FFFF);
        exp_txn = 32'hFFFF_FFFF;
        applyStimulus(64'h8000_0000, 8'h00, 64'h0, 64'hAA22_3344_5566_7711, 1'b1, 1'b0, 1'b0);

        // Back-to-back on the LATENCY=1 instance: accept every other cycle.
        @(posedge clk); #1;
        dreq1.valid  = 1'b1;
        dreq1.addr   = 64'h8000_0000;
        dreq1.size   = 3'd3;
        dreq1.strobe = 8'hFF;
        dreq1.data   = 64'h5A5A_A5A5_1234_5678;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput("b2b addr_ok", 64'(dresp1.addr_ok), 64'((i % 2) == 0));
            checkOutput("b2b data_ok", 64'(dresp1.data_ok), 64'((i % 2) == 1));
            if ((i % 2) == 0) sb1_q.push_back(mk_exp(64'h5A5A_A5A5_1234_5678, 1'b0, i != 0));
        end
        @(posedge clk); #1;
        dreq1.valid = 1'b0;
        @(negedge clk);
        checkOutput("b2b txn_cnt", 64'(txn_cnt1), 64'd4);

        checkOutput("scoreboard drained", 64'(sb_q.size()), 64'h0);
        checkOutput("dut1 scoreboard drained", 64'(sb1_q.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
